lmsm_sequencer: RTL
===================

# lmsm_sequencer

Multi-cycle sequencer for the load-multiple (LM) and store-multiple (SM) instructions. It sits directly upstream of the 8×16 register file. For each set bit of an 8-bit register mask, it generates one register address, one memory address and the matching strobes, lowest register first. On LM it drives the register file's active-low write strobe; on SM it drives the register file's read address and a memory write.

## Interface

Parameters: none. Widths are fixed: 16-bit data/address, 3-bit register index.

- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- is_lm  input  1  1 = LM (memory→registers), 0 = SM (registers→memory); latched on accepted start
- mask  input  8  register mask, bit i selects R_i; latched on accepted start
- base_addr  input  16  first memory address; latched on accepted start
- hold  input  1  memory not ready; freezes the current transfer
- reg_addr  output  3  register index of current transfer (write_select on LM, readAdd on SM)
- rf_write_n  output  1  active-low register file write strobe
- mem_addr  output  16  memory address of current transfer
- mem_re  output  1  memory read strobe (LM)
- mem_we  output  1  memory write strobe (SM)
- busy  output  1  high in RUN
- done  output  1  one-cycle completion pulse
- xfer_count  output  4  transfers completed for current instruction, 0–8

## Operation

- States: IDLE, RUN, DONE. All registers are updated only on clk rising edge.
- IDLE:
  - If start=1, latch mask→rem_mask, base_addr→cur_addr, is_lm→mode, and clear xfer_count.
  - If the latched mask is nonzero, go to RUN; if it is 0, go straight to DONE.
  - start=0: remain in IDLE.
- RUN:
  - reg_addr = index of the lowest set bit of rem_mask (priority encoder, bit 0 highest priority). mem_addr = cur_addr.
  - LM: mem_re=1, mem_we=0, rf_write_n = hold (low only when hold=0).
  - SM: mem_we=1, mem_re=0, rf_write_n=1.
- Transfer completion in RUN: a transfer completes on an edge where hold=0. On that edge:
  - clear that bit of rem_mask;
  - cur_addr ← cur_addr+1, modulo 2^16 (0xFFFF wraps to 0x0000);
  - xfer_count ← xfer_count+1;
  - if rem_mask becomes 0, go to DONE.
- hold=1 in RUN: all state is frozen and the strobes stay asserted, but rf_write_n stays 1.
- DONE: done=1, busy=0, all strobes inactive, rf_write_n=1; go to IDLE on the next edge.
- start is ignored in RUN and DONE; there is no queuing.
- Outside RUN: rf_write_n=1, mem_re=0, mem_we=0. reg_addr and mem_addr keep their last values.
- reset=0 on any edge, including mid-RUN with hold asserted, forces IDLE and the reset values below. Partial transfers are abandoned.

## Timing

- Reset values: reg_addr=0, mem_addr=0x0000, rf_write_n=1, mem_re=0, mem_we=0, busy=0, done=0, xfer_count=0, state=IDLE.
- start accepted at edge 0 with N set bits and no holds:
  - RUN occupies cycles 1..N;
  - done is high in cycle N+1;
  - IDLE from cycle N+2; the earliest next start is accepted at edge N+2.
- Each hold cycle extends RUN by exactly one cycle.
- Empty mask: done is high in cycle 1, with no strobes at all.
- rf_write_n is combinational from state, mode and hold. The register file captures on the edge closing the cycle in which rf_write_n=0.
- reg_addr and mem_addr are stable for the whole cycle; both are derived from registers only.

## Test plan

- LM, mask=0x05, base=0x0100, no hold → cycle 1: reg_addr=0, mem_addr=0x0100, rf_write_n=0; cycle 2: reg_addr=2, mem_addr=0x0101, rf_write_n=0; done in cycle 3; xfer_count=2.
- SM, mask=0x80, base=0x2000, hold=1 during cycles 1–2 → mem_we=1 with reg_addr=7, mem_addr=0x2000 for cycles 1–3; rf_write_n=1 throughout; done in cycle 4.
- LM, mask=0xFF, base=0xFFFE → reg_addr 0..7 in order; mem_addr 0xFFFE, 0xFFFF, 0x0000 … 0x0005; done in cycle 9; xfer_count=8.
- mask=0x00 → done in cycle 1; no mem_re, mem_we or rf_write_n=0 at any point.
- start pulsed again in cycle 2 of a mask=0x0F LM → ignored; exactly 4 transfers are issued with the original base.
- reset=0 asserted in cycle 2 of a mask=0x0F LM with hold=1 → next cycle shows IDLE, rf_write_n=1, mem_re=0, xfer_count=0, busy=0.

Source files
------------

// File: rtl/lmsm_sequencer_if.sv
// Bus between the LM/SM instruction issue logic and the sequencer.
// Handshake: start is a one-cycle request accepted only while busy=0 and done=0;
// hold=1 means memory is not ready and freezes the transfer on that edge.
interface lmsm_sequencer_if;
  logic        start;
  logic        is_lm;
  logic [7:0]  mask;
  logic [15:0] base_addr;
  logic        hold;
  logic [2:0]  reg_addr;
  logic        rf_write_n;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic [3:0]  xfer_count;
  logic [1:0]  state;

  modport master (
    output start, is_lm, mask, base_addr, hold,
    input  reg_addr, rf_write_n, mem_addr, mem_re, mem_we, busy, done, xfer_count, state
  );

  modport slave (
    input  start, is_lm, mask, base_addr, hold,
    output reg_addr, rf_write_n, mem_addr, mem_re, mem_we, busy, done, xfer_count, state
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: walks the set bits of a register mask lowest
// first, issuing one register/memory transfer per bit.
module lmsm_sequencer (
  input  logic              clk,
  input  logic              reset,
  lmsm_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  rem_mask;
  logic [15:0] cur_addr;
  logic        mode;
  logic [3:0]  count;
  logic [2:0]  last_reg;
  logic [15:0] last_mem;
  logic [2:0]  low_idx;
  logic [7:0]  rem_next;
  logic        complete;

  // Priority encoder: bit 0 wins.
  always_comb begin
    low_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (rem_mask[i]) low_idx = 3'(i);
    end
  end

  assign rem_next = rem_mask & ~(8'd1 << low_idx);
  assign complete = (state_q == RUN) && !bus.hold;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = (bus.mask != 8'd0) ? RUN : DONE;
      RUN:  if (complete && rem_next == 8'd0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rem_mask <= '0;
      cur_addr <= '0;
      mode     <= 1'b0;
      count    <= '0;
      last_reg <= '0;
      last_mem <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        rem_mask <= bus.mask;
        cur_addr <= bus.base_addr;
        mode     <= bus.is_lm;
        count    <= '0;
      end
      // Snapshot the live addresses so they persist once RUN is left.
      if (state_q == RUN) begin
        last_reg <= low_idx;
        last_mem <= cur_addr;
      end
      if (complete) begin
        rem_mask <= rem_next;
        cur_addr <= cur_addr + 16'd1;
        count    <= count + 4'd1;
      end
    end
  end

  always_comb begin
    bus.reg_addr   = last_reg;
    bus.mem_addr   = last_mem;
    bus.rf_write_n = 1'b1;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.xfer_count = count;
    bus.state      = state_q;
    case (state_q)
      RUN: begin
        bus.busy     = 1'b1;
        bus.reg_addr = low_idx;
        bus.mem_addr = cur_addr;
        if (mode) begin
          bus.mem_re     = 1'b1;
          bus.rf_write_n = bus.hold;
        end else begin
          bus.mem_we = 1'b1;
        end
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
